clkdiv_cfg_ctrl: RTL and testbench

//  Config/enable controller that drives the integer clock divider's ratio and enable inputs.

---
 rtl/clkdiv_cfg_if.sv | 10 +
 rtl/clkdiv_cfg_ctrl.sv | 98 +++++++++
 tb/tb_clkdiv_cfg_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clkdiv_cfg_if.sv
// clkdiv_cfg_if: valid/ready ratio-update channel between the register file and the divider controller.
interface clkdiv_cfg_if #(
    parameter int WIDTH = 6
) ();
    logic             valid;
    logic [WIDTH-1:0] ratio;
    logic             ready;
    modport master (output valid, output ratio, input ready);
    modport slave  (input valid, input ratio, output ready);
endinterface

// File: rtl/clkdiv_cfg_ctrl.sv
// clkdiv_cfg_ctrl: commits divider ratio/enable only at divided-period boundaries and emits a period tick.
// Optional CLKDIV_CFG_CLAMP_EN: illegal ratios are clamped to MIN_RATIO instead of rejected.
module clkdiv_cfg_ctrl #(
    parameter int WIDTH     = 6,
    parameter int MIN_RATIO = 2,
    parameter int RST_RATIO = 2
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    clkdiv_cfg_if.slave      cfg,
    input  logic             enable,
    output logic [WIDTH-1:0] div_ratio,
    output logic             clk_en,
    output logic             period_tick,
    output logic             cfg_err,
    output logic             busy
);
    typedef enum logic [1:0] {OFF, RUN, PEND} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d, shadow, shadow_d, ratio_d, req, cnt_nxt;
    logic             en_d, tick_d, err_d, acc, xfer, bnd, legal;
    assign xfer  = cfg.valid && cfg.ready;
    assign legal = cfg.ratio >= WIDTH'(MIN_RATIO);
`ifdef CLKDIV_CFG_CLAMP_EN
    assign acc = xfer;
    assign req = legal ? cfg.ratio : WIDTH'(MIN_RATIO);
`else
    assign acc = xfer && legal;
    assign req = cfg.ratio;
`endif
    assign bnd     = (state != OFF) && (cnt == div_ratio - WIDTH'(1));
    assign cnt_nxt = bnd ? '0 : cnt + WIDTH'(1);
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        shadow_d = shadow;
        ratio_d  = div_ratio;
        en_d     = clk_en;
        tick_d   = 1'b0;
        err_d    = xfer && !legal;
        unique case (state)
            OFF: begin
                cnt_d   = '0;
                ratio_d = acc ? req : div_ratio;
                if (enable) begin
                    state_d = RUN;
                    en_d    = 1'b1;
                end
            end
            RUN: begin
                cnt_d  = cnt_nxt;
                tick_d = bnd;
                // a disable sampled at a boundary wins over a same-cycle transfer, which commits directly
                if (bnd && !enable) begin
                    state_d = OFF;
                    en_d    = 1'b0;
                    ratio_d = acc ? req : div_ratio;
                end else if (acc) begin
                    shadow_d = req;
                    state_d  = PEND;
                end
            end
            PEND: begin
                cnt_d  = cnt_nxt;
                tick_d = bnd;
                if (bnd) begin
                    ratio_d = shadow;
                    state_d = enable ? RUN : OFF;
                    en_d    = enable;
                end
            end
            default: state_d = OFF;
        endcase
    end
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= OFF;
            cnt         <= '0;
            shadow      <= '0;
            div_ratio   <= WIDTH'(RST_RATIO);
            clk_en      <= 1'b0;
            period_tick <= 1'b0;
            cfg_err     <= 1'b0;
            cfg.ready   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            shadow      <= shadow_d;
            div_ratio   <= ratio_d;
            clk_en      <= en_d;
            period_tick <= tick_d;
            cfg_err     <= err_d;
            cfg.ready   <= state_d != PEND;
            busy        <= state_d == PEND;
        end
    end
endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// tb_clkdiv_cfg_ctrl: cycle-by-cycle vector table through a scoreboard queue plus reset/max-ratio sequences.
module tb_clkdiv_cfg_ctrl;
    typedef struct {
        int v, r, en;
        int e_ratio, e_en, e_tick, e_err, e_rdy, e_busy;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] div_ratio;
    logic       clk_en, period_tick, cfg_err, busy;
    int         total = 0;
    int         bad = 0;
    vec_t       tbl[$];
    vec_t       sb[$];
    clkdiv_cfg_if #(.WIDTH(6)) cfg ();
    clkdiv_cfg_ctrl #(.WIDTH(6), .MIN_RATIO(2), .RST_RATIO(2)) dut (
        .i_ref_clk(clk), .i_rst_n(rst_n), .cfg(cfg), .enable(enable),
        .div_ratio(div_ratio), .clk_en(clk_en), .period_tick(period_tick),
        .cfg_err(cfg_err), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask
    task automatic add(input int v, r, en, er, een, et, eerr, erdy, ebusy, input int n = 1);
        for (int k = 0; k < n; k++) tbl.push_back('{v, r, en, er, een, et, eerr, erdy, ebusy});
    endtask
    task automatic wait_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (period_tick) begin
                n = i;
                break;
            end
        end
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_ratio"}, int'(div_ratio), 2);
        check({tag, "_en"}, int'(clk_en), 0);
        check({tag, "_tick"}, int'(period_tick), 0);
        check({tag, "_err"}, int'(cfg_err), 0);
        check({tag, "_ready"}, int'(cfg.ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
    endtask
    initial begin
        int n;
        vec_t e;
        cfg.valid = 1'b0;
        cfg.ratio = '0;
        add(0,0,1, 2,1,0,0,1,0, 2);
        add(0,0,1, 2,1,1,0,1,0);
        add(0,0,1, 2,1,0,0,1,0);
        add(0,0,1, 2,1,1,0,1,0);
        add(0,0,0, 2,1,0,0,1,0);
        add(0,0,0, 2,0,1,0,1,0);
        add(1,1,0, 2,0,0,1,1,0);
        add(1,4,0, 4,0,0,0,1,0);
        add(0,0,1, 4,1,0,0,1,0, 2);
        add(1,7,1, 4,1,0,0,0,1);
        add(0,0,1, 4,1,0,0,0,1);
        add(0,0,1, 7,1,1,0,1,0);
        add(0,0,1, 7,1,0,0,1,0, 6);
        add(0,0,1, 7,1,1,0,1,0);
        add(1,1,1, 7,1,0,1,1,0);
        add(0,0,1, 7,1,0,0,1,0, 5);
        add(1,3,1, 7,1,1,0,0,1);
        add(0,0,1, 7,1,0,0,0,1, 6);
        add(0,0,1, 3,1,1,0,1,0);
        add(0,0,1, 3,1,0,0,1,0, 2);
        add(1,5,0, 5,0,1,0,1,0);
        add(0,0,0, 5,0,0,0,1,0);
        add(1,6,0, 6,0,0,0,1,0);
        add(0,0,1, 6,1,0,0,1,0, 3);
        add(0,0,0, 6,1,0,0,1,0, 3);
        add(0,0,0, 6,0,1,0,1,0);
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            cfg.valid = tbl[i].v[0];
            cfg.ratio = 6'(tbl[i].r);
            enable    = tbl[i].en[0];
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_ratio", i), int'(div_ratio), e.e_ratio);
            check($sformatf("vec%0d_en", i), int'(clk_en), e.e_en);
            check($sformatf("vec%0d_tick", i), int'(period_tick), e.e_tick);
            check($sformatf("vec%0d_err", i), int'(cfg_err), e.e_err);
            check($sformatf("vec%0d_ready", i), int'(cfg.ready), e.e_rdy);
            check($sformatf("vec%0d_busy", i), int'(busy), e.e_busy);
        end
        @(negedge clk);
        cfg.valid = 1'b1;
        cfg.ratio = 6'd63;
        enable    = 1'b1;
        @(negedge clk);
        cfg.valid = 1'b0;
        check("max_ratio", int'(div_ratio), 63);
        wait_tick(200, n);
        check("max_first_tick_seen", int'(n > 0), 1);
        wait_tick(200, n);
        check("max_tick_interval", n, 63);
        @(negedge clk);
        cfg.valid = 1'b1;
        cfg.ratio = 6'd9;
        @(posedge clk);
        #1;
        check("pend_busy", int'(busy), 1);
        check("pend_ready", int'(cfg.ready), 0);
        check("pend_ratio_old", int'(div_ratio), 63);
        @(negedge clk);
        cfg.valid = 1'b0;
        enable    = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("post_rst");
        @(negedge clk);
        enable = 1'b1;
        wait_tick(20, n);
        check("post_rst_first_tick_seen", int'(n > 0), 1);
        wait_tick(20, n);
        check("post_rst_interval", n, 2);
        check("post_rst_ratio", int'(div_ratio), 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
